// File: rtl/posit_construction.sv
// Posit encoder: packs sign/regime/exponent/mantissa into an N-bit posit with RNE rounding and
// maxpos/minpos saturation. Three register stages, one global advance enable (stall holds all).
module posit_construction #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                Sign,
  input  logic signed [RS:0]  k,
  input  logic [ES-1:0]       Exponent,
  input  logic [N-1:0]        Mantissa,
  input  logic                inf,
  input  logic                zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        Posit
);

  localparam int BW = N + ES;
  localparam int WW = 2 * N;
  localparam logic signed [RS+1:0] KMAX = (RS+2)'(N - 2);
  localparam logic signed [RS+1:0] KMIN = (RS+2)'(-(N - 1));

  logic en;
  logic out_valid_q;
  logic [N-1:0] posit_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign Posit     = posit_q;

  // ---------------- S1: regime length and packed body ----------------
  logic signed [RS+1:0] k_ext;
  logic                 kpos_d;
  logic [RS+1:0]        shamt_d;
  logic [BW-1:0]        body_d;
  logic                 sat_hi_d, sat_lo_d;
  logic                 unused_hidden;

  logic                 v1_q, inf1_q, zero1_q, sign1_q, kpos1_q, sat_hi1_q, sat_lo1_q;
  logic [RS+1:0]        shamt1_q;
  logic [BW-1:0]        body1_q;

  assign unused_hidden = Mantissa[N-1];

  // Body = regime terminator, exponent, fraction; the regime run itself is made by the shift in S2.
  always_comb begin
    k_ext    = {k[RS], k};
    kpos_d   = !k[RS];
    shamt_d  = kpos_d ? k_ext + (RS+2)'(1) : -k_ext;
    body_d   = {!kpos_d, Exponent, Mantissa[N-2:0]};
    sat_hi_d = (k_ext >= KMAX);
    sat_lo_d = (k_ext <= KMIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      inf1_q    <= 1'b0;
      zero1_q   <= 1'b0;
      sign1_q   <= 1'b0;
      kpos1_q   <= 1'b0;
      sat_hi1_q <= 1'b0;
      sat_lo1_q <= 1'b0;
      shamt1_q  <= '0;
      body1_q   <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        inf1_q    <= inf;
        zero1_q   <= zero;
        sign1_q   <= Sign;
        kpos1_q   <= kpos_d;
        sat_hi1_q <= sat_hi_d;
        sat_lo1_q <= sat_lo_d;
        shamt1_q  <= shamt_d;
        body1_q   <= body_d;
      end
    end
  end

  // ---------------- S2: shift, round, saturate ----------------
  logic [WW-1:0] work;
  logic [N-2:0]  kept, rnd, mag_d;
  logic          guard, sticky;

  logic          v2_q, inf2_q, zero2_q, sign2_q;
  logic [N-2:0]  mag2_q;

  always_comb begin
    work = {body1_q, {(WW-BW){1'b0}}} >> shamt1_q;
    if (kpos1_q) work = work | ~({WW{1'b1}} >> shamt1_q);
    kept   = work[WW-1 -: N-1];
    guard  = work[WW-N];
    sticky = |work[WW-N-1:0];
    rnd    = kept + (N-1)'(guard & (sticky | kept[0]));
    if (sat_hi1_q)                   mag_d = '1;
    else if (sat_lo1_q || rnd == '0) mag_d = (N-1)'(1);
    else                             mag_d = rnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      inf2_q  <= 1'b0;
      zero2_q <= 1'b0;
      sign2_q <= 1'b0;
      mag2_q  <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        inf2_q  <= inf1_q;
        zero2_q <= zero1_q;
        sign2_q <= sign1_q;
        mag2_q  <= mag_d;
      end
    end
  end

  // ---------------- S3: specials, sign, output register ----------------
  logic [N-1:0] pos, posit_d;

  always_comb begin
    pos = {1'b0, mag2_q};
    if (inf2_q)       posit_d = {1'b1, {(N-1){1'b0}}};
    else if (zero2_q) posit_d = '0;
    else if (sign2_q) posit_d = -pos;
    else              posit_d = pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      posit_q     <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      if (v2_q) posit_q <= posit_d;
    end
  end

endmodule

// File: tb/tb_posit_construction.sv
// Directed bench for posit_construction: encodings, rounding, saturation, backpressure,
// mid-stream reset and a decode/encode round trip.
module tb_posit_construction;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               Sign;
  logic signed [5:0]  k;
  logic [1:0]         Exponent;
  logic [31:0]        Mantissa;
  logic               inf;
  logic               zero;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        Posit;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic              s;
    logic signed [5:0] kk;
    logic [1:0]        e;
    logic [31:0]       m;
    logic              fi;
    logic              fz;
    logic [31:0]       want;
  } vec_t;

  posit_construction dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sign(Sign), .k(k), .Exponent(Exponent), .Mantissa(Mantissa),
    .inf(inf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready), .Posit(Posit)
  );

  always #5 clk = ~clk;

  // Presents one item for exactly one accepting edge, then scrambles the fields.
  task automatic send(input logic s, input logic signed [5:0] kk, input logic [1:0] e,
                      input logic [31:0] m, input logic fi, input logic fz);
    @(posedge clk); #1;
    Sign = s; k = kk; Exponent = e; Mantissa = m; inf = fi; zero = fz; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; Sign = ~s; k = ~kk; Exponent = ~e; Mantissa = ~m; inf = 1'b0; zero = 1'b0;
  endtask

  // Number of falling edges after the accept edge until out_valid; 0 if never seen.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic void decode(input logic [31:0] p, output logic s, output logic signed [5:0] kk,
                                 output logic [1:0] e, output logic [31:0] m,
                                 output logic fi, output logic fz);
    logic [31:0] mag;
    logic [63:0] t;
    logic        r0;
    int          n;
    fi  = (p == 32'h80000000);
    fz  = (p == 32'h0);
    s   = p[31];
    mag = p[31] ? -p : p;
    r0  = mag[30];
    n   = 0;
    for (int b = 30; b >= 0; b--) begin
      if (mag[b] == r0) n++;
      else break;
    end
    kk = r0 ? 6'(n - 1) : 6'(-n);
    t  = {mag[30:0], 33'b0} << (n + 1);
    e  = t[63:62];
    m  = {1'b1, t[61:31]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Sign = 1'b0; k = '0; Exponent = '0; Mantissa = '0; inf = 1'b0; zero = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (Posit !== 32'h0) begin n_bad++; $display("FAIL reset_posit got %h want 00000000", Posit); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    vec_t v [21];
    int lat;
    v[0]  = '{1'b0,  6'sd0,  2'd0, 32'h80000000, 1'b0, 1'b0, 32'h40000000};
    v[1]  = '{1'b1,  6'sd0,  2'd0, 32'h80000000, 1'b0, 1'b0, 32'hC0000000};
    v[2]  = '{1'b0,  6'sd0,  2'd1, 32'h80000000, 1'b0, 1'b0, 32'h48000000};
    v[3]  = '{1'b0,  6'sd0,  2'd0, 32'hC0000000, 1'b0, 1'b0, 32'h44000000};
    v[4]  = '{1'b0,  6'sd0,  2'd0, 32'h80000008, 1'b0, 1'b0, 32'h40000000};
    v[5]  = '{1'b0,  6'sd0,  2'd0, 32'h80000018, 1'b0, 1'b0, 32'h40000002};
    v[6]  = '{1'b0,  6'sd0,  2'd0, 32'h80000009, 1'b0, 1'b0, 32'h40000001};
    v[7]  = '{1'b1,  6'sd0,  2'd0, 32'h80000000, 1'b1, 1'b0, 32'h80000000};
    v[8]  = '{1'b1,  6'sd0,  2'd0, 32'h80000000, 1'b0, 1'b1, 32'h00000000};
    v[9]  = '{1'b0,  6'sd0,  2'd0, 32'h80000000, 1'b1, 1'b1, 32'h80000000};
    v[10] = '{1'b0,  6'sd30, 2'd0, 32'h80000000, 1'b0, 1'b0, 32'h7FFFFFFF};
    v[11] = '{1'b0,  6'sd31, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF};
    v[12] = '{1'b0, -6'sd31, 2'd0, 32'h80000000, 1'b0, 1'b0, 32'h00000001};
    v[13] = '{1'b1, -6'sd31, 2'd0, 32'h80000000, 1'b0, 1'b0, 32'hFFFFFFFF};
    v[14] = '{1'b0, -6'sd32, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001};
    v[15] = '{1'b0,  6'sd29, 2'd0, 32'h80000000, 1'b0, 1'b0, 32'h7FFFFFFE};
    v[16] = '{1'b0,  6'sd28, 2'd3, 32'h80000000, 1'b0, 1'b0, 32'h7FFFFFFE};
    v[17] = '{1'b0,  6'sd28, 2'd2, 32'h80000000, 1'b0, 1'b0, 32'h7FFFFFFD};
    v[18] = '{1'b0, -6'sd1,  2'd3, 32'h80000000, 1'b0, 1'b0, 32'h38000000};
    v[19] = '{1'b0, -6'sd30, 2'd3, 32'hC0000000, 1'b0, 1'b0, 32'h00000002};
    v[20] = '{1'b1,  6'sd2,  2'd2, 32'hA0000000, 1'b0, 1'b0, 32'h8B800000};
    for (int i = 0; i < 21; i++) begin
      send(v[i].s, v[i].kk, v[i].e, v[i].m, v[i].fi, v[i].fz);
      wait_out(lat);
      n_cmp++;
      if (lat !== 3) begin n_bad++; $display("FAIL directed[%0d] latency got %0d want 3", i, lat); end
      n_cmp++;
      if (Posit !== v[i].want) begin n_bad++; $display("FAIL directed[%0d] posit got %h want %h", i, Posit, v[i].want); end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL directed[%0d] bubble out_valid got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int          got;
    logic        held_vld;
    logic [31:0] held;
    logic [31:0] want;
    logic [15:0] pat;
    got = 0; held_vld = 1'b0; held = '0; pat = 16'hB38D;
    fork
      begin
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
          Sign = 1'b0; k = '0; Exponent = '0; inf = 1'b0; zero = 1'b0;
          Mantissa = 32'h80000000 | (32'(i) << 4);
          in_valid = 1'b1;
          for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (in_ready) break;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && got < 8; c++) begin
          @(posedge clk); #1;
          out_ready = pat[0];
          pat = {pat[14:0], pat[15] ^ pat[13] ^ pat[12] ^ pat[10]};
          @(negedge clk);
          n_cmp++;
          if (in_ready !== !(out_valid && !out_ready)) begin
            n_bad++; $display("FAIL bp_in_ready got %b want %b", in_ready, !(out_valid && !out_ready));
          end
          if (held_vld) begin
            n_cmp++;
            if (out_valid !== 1'b1 || Posit !== held) begin
              n_bad++; $display("FAIL bp_stall_hold got %b/%h want 1/%h", out_valid, Posit, held);
            end
          end
          held_vld = out_valid && !out_ready;
          held     = Posit;
          if (out_valid && out_ready) begin
            want = 32'h40000000 | 32'(got + 1);
            n_cmp++;
            if (Posit !== want) begin n_bad++; $display("FAIL bp_order[%0d] got %h want %h", got, Posit, want); end
            got++;
          end
        end
      end
    join
    n_cmp++;
    if (got !== 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", got); end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_extra cycle %0d out_valid got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    int lat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    Sign = 1'b0; k = 6'sd3; Exponent = 2'd1; Mantissa = 32'h80000000; inf = 1'b0; zero = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1 k = 6'sd4;
    @(posedge clk); #1 k = 6'sd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
    n_cmp++; if (Posit !== 32'h0) begin n_bad++; $display("FAIL mid_reset_posit got %h want 00000000", Posit); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stale cycle %0d out_valid got %b want 0", c, out_valid); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
    send(1'b0, 6'sd1, 2'd0, 32'h80000000, 1'b0, 1'b0);
    wait_out(lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mid_reset_latency got %0d want 3", lat); end
    n_cmp++; if (Posit !== 32'h60000000) begin n_bad++; $display("FAIL mid_reset_posit_new got %h want 60000000", Posit); end
  endtask

  task automatic test_roundtrip();
    logic [31:0]       p [46];
    logic              s, fi, fz;
    logic signed [5:0] kk;
    logic [1:0]        e;
    logic [31:0]       m;
    int                lat;
    p[0] = 32'h00000000; p[1] = 32'h80000000; p[2] = 32'h7FFFFFFF; p[3] = 32'h00000001;
    p[4] = 32'hFFFFFFFF; p[5] = 32'h80000001; p[6] = 32'h40000000; p[7] = 32'hC0000000;
    for (int i = 8; i < 46; i++) p[i] = $urandom;
    out_ready = 1'b1;
    for (int i = 0; i < 46; i++) begin
      decode(p[i], s, kk, e, m, fi, fz);
      send(s, kk, e, m, fi, fz);
      wait_out(lat);
      n_cmp++;
      if (lat !== 3 || Posit !== p[i]) begin
        n_bad++; $display("FAIL roundtrip[%0d] got %h (lat %0d) want %h (lat 3)", i, Posit, lat, p[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
